// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters gating GRF operand reads at issue; updates are visible one cycle later.
// Backpressure: stall holds issue while a source has an in-flight writer or the destination counter is saturated.
module reg_scoreboard #(
  parameter int CNT_W    = 2,
  parameter int MAX_PEND = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iss_valid,
  input  logic       iss_use1,
  input  logic       iss_use2,
  input  logic [4:0] iss_a1,
  input  logic [4:0] iss_a2,
  input  logic       iss_we,
  input  logic [4:0] iss_a3,
  input  logic       kill,
  input  logic [4:0] kill_a3,
  input  logic       ret_we,
  input  logic [4:0] ret_a3,
  output logic       stall,
  output logic       rdy1,
  output logic       rdy2,
  output logic       idle,
  output logic       err
);

  // Entry 0 exists only so lookups with address 0 stay in range; it is held at zero.
  logic [CNT_W-1:0] cnt [0:31];
  logic             err_q;

  logic raw_rdy1, raw_rdy2, full, raw_stall, acc, any_pend;

  always_comb begin
    raw_rdy1  = (iss_a1 == 5'd0) || (cnt[iss_a1] == '0);
    raw_rdy2  = (iss_a2 == 5'd0) || (cnt[iss_a2] == '0);
    full      = iss_we && (iss_a3 != 5'd0) && (cnt[iss_a3] == CNT_W'(MAX_PEND));
    raw_stall = iss_valid && ((iss_use1 && !raw_rdy1) || (iss_use2 && !raw_rdy2) || full);
    acc       = iss_valid && !raw_stall;
  end

  always_comb begin
    any_pend = 1'b0;
    for (int r = 1; r < 32; r++) begin
      if (cnt[r] != '0) any_pend = 1'b1;
    end
  end

  // While in reset the pipe must not issue, and every register reads as clean.
  always_comb begin
    stall = reset ? raw_stall : 1'b1;
    rdy1  = reset ? raw_rdy1  : 1'b1;
    rdy2  = reset ? raw_rdy2  : 1'b1;
    idle  = reset ? !any_pend : 1'b1;
    err   = err_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        logic             inc;
        logic [1:0]       dec;
        logic [CNT_W:0]   up;
        inc = acc && iss_we && (iss_a3 == 5'(r));
        dec = {1'b0, (ret_we && (ret_a3 == 5'(r)))} + {1'b0, (kill && (kill_a3 == 5'(r)))};
        up  = {1'b0, cnt[r]} + (CNT_W+1)'(inc);
        // A release with no matching writer clamps to zero and flags the bookkeeping error.
        if (up < (CNT_W+1)'(dec)) begin
          cnt[r] <= '0;
          err_q  <= 1'b1;
        end else begin
          cnt[r] <= CNT_W'(up - (CNT_W+1)'(dec));
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: inputs change 1ns after posedge, outputs sampled 2ns later.
module tb_reg_scoreboard;

  logic       clk;
  logic       reset;
  logic       iss_valid, iss_use1, iss_use2, iss_we;
  logic [4:0] iss_a1, iss_a2, iss_a3;
  logic       kill, ret_we;
  logic [4:0] kill_a3, ret_a3;
  logic       stall, rdy1, rdy2, idle, err;

  int n_checks = 0;
  int n_fails  = 0;

  reg_scoreboard #(.CNT_W(2), .MAX_PEND(3)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_use1(iss_use1), .iss_use2(iss_use2),
    .iss_a1(iss_a1), .iss_a2(iss_a2), .iss_we(iss_we), .iss_a3(iss_a3),
    .kill(kill), .kill_a3(kill_a3), .ret_we(ret_we), .ret_a3(ret_a3),
    .stall(stall), .rdy1(rdy1), .rdy2(rdy2), .idle(idle), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic clr();
    iss_valid = 0; iss_use1 = 0; iss_use2 = 0; iss_we = 0;
    iss_a1 = 0; iss_a2 = 0; iss_a3 = 0;
    kill = 0; kill_a3 = 0; ret_we = 0; ret_a3 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 0;
    clr();
    // Reset: outputs forced while reset is low
    iss_valid = 1; iss_use1 = 1; iss_a1 = 5;
    settle();
    chk("rst_stall_forced", stall, 1'b1);
    chk("rst_rdy1_forced", rdy1, 1'b1);
    chk("rst_idle_forced", idle, 1'b1);
    tick(); tick();
    reset = 1;
    settle();
    chk("post_rst_idle", idle, 1'b1);
    chk("post_rst_err", err, 1'b0);
    chk("post_rst_stall", stall, 1'b0);

    // Basic RAW on r8
    tick(); clr();
    iss_valid = 1; iss_we = 1; iss_a3 = 8;
    settle();
    chk("raw_issue_w8", stall, 1'b0);
    tick(); clr();
    iss_valid = 1; iss_use1 = 1; iss_a1 = 8;
    settle();
    chk("raw_stall", stall, 1'b1);
    chk("raw_rdy1", rdy1, 1'b0);
    chk("raw_idle", idle, 1'b0);
    tick();
    ret_we = 1; ret_a3 = 8;
    settle();
    chk("raw_ret_same_cycle_stall", stall, 1'b1);
    chk("raw_ret_same_cycle_rdy1", rdy1, 1'b0);
    tick();
    ret_we = 0; ret_a3 = 0;
    settle();
    chk("raw_after_ret_stall", stall, 1'b0);
    chk("raw_after_ret_rdy1", rdy1, 1'b1);
    chk("raw_after_ret_idle", idle, 1'b1);

    // $0 is never tracked
    tick(); clr();
    iss_valid = 1; iss_we = 1; iss_a3 = 0;
    tick(); clr();
    settle();
    chk("r0_write_idle", idle, 1'b1);
    iss_valid = 1; iss_use1 = 1; iss_a1 = 0; iss_use2 = 1; iss_a2 = 0;
    settle();
    chk("r0_rdy1", rdy1, 1'b1);
    chk("r0_rdy2", rdy2, 1'b1);
    chk("r0_stall", stall, 1'b0);
    tick(); clr();
    ret_we = 1; ret_a3 = 0; kill = 1; kill_a3 = 0;
    tick(); clr();
    settle();
    chk("r0_ret_no_err", err, 1'b0);
    chk("r0_ret_idle", idle, 1'b1);

    // Saturation on r9
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1; iss_we = 1; iss_a3 = 9;
      settle();
      chk($sformatf("sat_issue_%0d", i), stall, 1'b0);
      tick();
    end
    settle();
    chk("sat_full_stall", stall, 1'b1);
    tick(); clr();
    iss_use2 = 1; iss_a2 = 9;
    settle();
    chk("sat_rdy2", rdy2, 1'b0);
    clr();
    ret_we = 1; ret_a3 = 9;
    tick(); tick();
    settle();
    chk("sat_two_ret_idle", idle, 1'b0);
    tick(); clr();
    settle();
    chk("sat_three_ret_idle", idle, 1'b1);
    chk("sat_no_err", err, 1'b0);

    // Simultaneous issue/retire and kill/retire on r4
    iss_valid = 1; iss_we = 1; iss_a3 = 4;
    tick();
    ret_we = 1; ret_a3 = 4;
    settle();
    chk("sim_issue_ret_acc", stall, 1'b0);
    tick(); clr();
    iss_a1 = 4;
    settle();
    chk("sim_issue_ret_rdy1", rdy1, 1'b0);
    iss_valid = 1; iss_we = 1; iss_a3 = 4;
    tick(); clr();
    kill = 1; kill_a3 = 4; ret_we = 1; ret_a3 = 4;
    tick(); clr();
    settle();
    chk("sim_kill_ret_idle", idle, 1'b1);
    chk("sim_kill_ret_err", err, 1'b0);

    // Underflow on r12, sticky err, then mid-run reset
    ret_we = 1; ret_a3 = 12;
    settle();
    chk("uf_err_before_edge", err, 1'b0);
    tick(); clr();
    settle();
    chk("uf_err_set", err, 1'b1);
    tick(); tick();
    settle();
    chk("uf_err_sticky", err, 1'b1);
    iss_valid = 1; iss_we = 1; iss_a3 = 12;
    tick(); clr();
    iss_a1 = 12;
    settle();
    chk("uf_pending_idle", idle, 1'b0);
    chk("uf_pending_rdy1", rdy1, 1'b0);
    reset = 0;
    settle();
    chk("mid_rst_stall_forced", stall, 1'b1);
    tick();
    reset = 1;
    settle();
    chk("mid_rst_err_clr", err, 1'b0);
    chk("mid_rst_idle", idle, 1'b1);
    chk("mid_rst_rdy1", rdy1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
